// File: rtl/sample_frame_buffer_pkg.sv
// -----------------------------------------------------------------------------
// sample_frame_buffer_pkg
// Shared definitions for the stereo-to-mono ping-pong frame buffer:
//   - default sample width and frame length
//   - write-FSM state encoding (FILL / STALL)
//   - mono_avg(): (a + b) >>> 1 computed one bit wider than its operands
// No ports (package).
// -----------------------------------------------------------------------------
package sample_frame_buffer_pkg;

  localparam int DATA_BITS_DEFAULT = 16;
  localparam int FRAME_LEN_DEFAULT = 256;

  // Write-side FSM encoding.
  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Average of two signed values. Callers sign-extend their DATA_BITS-wide
  // operands to 32 bits and truncate the result back. The 33-bit sum cannot
  // overflow, and after the shift the result always fits the operand width.
  function automatic logic signed [31:0] mono_avg(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    logic signed [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    return sum[32:1];
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// -----------------------------------------------------------------------------
// frame_bank_ram
// One frame bank: simple dual-port RAM with one write port and one registered
// read port, written so that it infers block RAM.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset of the read register only
//   we       in   write enable
//   wr_addr  in   ADDR_BITS write address
//   wr_data  in   DATA_BITS write data
//   rd_addr  in   ADDR_BITS read address
//   rd_data  out  DATA_BITS registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module frame_bank_ram #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // NOTE: the storage array has no reset; resetting it would prevent block-RAM
  // inference, and stale contents are never exposed as a ready frame.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // The output register takes a synchronous reset, which block RAM supports.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// -----------------------------------------------------------------------------
// sample_frame_buffer
// Converts stereo sample pairs to mono and collects them into frames of
// FRAME_LEN words, held in two ping-pong banks. The consumer reads a complete
// frame by address and releases it when done. When both banks are full,
// incoming samples are dropped and a sticky overflow flag is set.
// Optional build macro FRAME_BUF_DECIM2_EN: decimate the mono stream by 2 by
// averaging consecutive samples before they are stored.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   sample_L_i       in   DATA_BITS signed left sample
//   sample_R_i       in   DATA_BITS signed right sample
//   sample_valid_i   in   one-cycle strobe qualifying L/R
//   frame_ready_o    out  a complete frame is readable
//   rd_addr_i        in   log2(FRAME_LEN) read index into the ready frame
//   rd_data_o        out  DATA_BITS sample at rd_addr_i, one cycle later
//   frame_release_i  in   one-cycle strobe: consumer is done with the frame
//   overflow_o       out  sticky: at least one sample was dropped
// -----------------------------------------------------------------------------
module sample_frame_buffer
  import sample_frame_buffer_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_BITS-1:0] sample_L_i,
  input  logic signed [DATA_BITS-1:0] sample_R_i,
  input  logic                        sample_valid_i,
  output logic                        frame_ready_o,
  input  logic        [ADDR_BITS-1:0] rd_addr_i,
  output logic        [DATA_BITS-1:0] rd_data_o,
  input  logic                        frame_release_i,
  output logic                        overflow_o
);

  logic signed [DATA_BITS-1:0] mono;
  logic                        acc_valid;
  logic signed [DATA_BITS-1:0] acc_data;

  assign mono = DATA_BITS'(mono_avg(32'(sample_L_i), 32'(sample_R_i)));

`ifdef FRAME_BUF_DECIM2_EN
  // The phase advances on every input strobe, including while stalled, so the
  // pairing of samples never depends on buffer occupancy.
  logic                        phase;
  logic signed [DATA_BITS-1:0] hold;

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      hold  <= '0;
    end else if (sample_valid_i) begin
      phase <= ~phase;
      if (!phase) hold <= mono;
    end
  end

  assign acc_valid = sample_valid_i & phase;
  assign acc_data  = DATA_BITS'(mono_avg(32'(hold), 32'(mono)));
`else
  assign acc_valid = sample_valid_i;
  assign acc_data  = mono;
`endif

  logic [0:0]           state;
  logic                 wr_bank;
  logic                 rd_bank;
  logic                 rd_sel;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 release_fire;
  logic                 other_free;
  logic                 wr_en;
  logic                 wr_last;
  logic [DATA_BITS-1:0] rd_data0;
  logic [DATA_BITS-1:0] rd_data1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    release_fire = frame_release_i & full[rd_bank];
    // A release of the other bank on this same edge counts as free, so a
    // frame completing together with a release never enters STALL.
    other_free   = ~full[~wr_bank] | (release_fire & (rd_bank != wr_bank));
    wr_en        = (state == ST_FILL) & acc_valid;
    wr_last      = (wr_idx == ADDR_BITS'(FRAME_LEN - 1));
    full_nxt     = full;
    if (release_fire)     full_nxt[rd_bank] = 1'b0;
    if (wr_en && wr_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_sel     <= 1'b0;
      wr_idx     <= '0;
      full       <= 2'b00;
      overflow_o <= 1'b0;
    end else begin
      full   <= full_nxt;
      // Remember which bank the current read address targets so the output
      // mux matches the registered RAM data.
      rd_sel <= rd_bank;
      if (release_fire) rd_bank <= ~rd_bank;

      case (state)
        ST_FILL: begin
          if (wr_en) begin
            if (wr_last) begin
              wr_idx <= '0;
              if (other_free) wr_bank <= ~wr_bank;
              else            state   <= ST_STALL;
            end else begin
              wr_idx <= wr_idx + ADDR_BITS'(1);
            end
          end
        end
        ST_STALL: begin
          if (acc_valid) overflow_o <= 1'b1;
          // Uses the registered flag: a release arriving while stalled
          // resumes filling on the following edge.
          if (!full[~wr_bank]) begin
            wr_bank <= ~wr_bank;
            wr_idx  <= '0;
            state   <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign frame_ready_o = full[rd_bank];

  frame_bank_ram #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en & ~wr_bank),
    .wr_addr (wr_idx),
    .wr_data (acc_data),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data0)
  );

  frame_bank_ram #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en & wr_bank),
    .wr_addr (wr_idx),
    .wr_data (acc_data),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data1)
  );

  assign rd_data_o = rd_sel ? rd_data1 : rd_data0;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_sample_frame_buffer
// Directed bench for sample_frame_buffer with FRAME_LEN=8, DATA_BITS=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the preceding edge.
// With FRAME_BUF_DECIM2_EN defined, the decimation sequence runs instead.
// -----------------------------------------------------------------------------
module tb_sample_frame_buffer;

  localparam int DB = 16;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] sample_l = '0;
  logic [DB-1:0] sample_r = '0;
  logic          sample_valid = 1'b0;
  logic          frame_ready;
  logic [2:0]    rd_addr = '0;
  logic [DB-1:0] rd_data;
  logic          frame_release = 1'b0;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  sample_frame_buffer #(.DATA_BITS(DB), .FRAME_LEN(FL)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_L_i      (sample_l),
    .sample_R_i      (sample_r),
    .sample_valid_i  (sample_valid),
    .frame_ready_o   (frame_ready),
    .rd_addr_i       (rd_addr),
    .rd_data_o       (rd_data),
    .frame_release_i (frame_release),
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DB-1:0] l, input logic [DB-1:0] r, input logic rel);
    sample_l      = l;
    sample_r      = r;
    sample_valid  = 1'b1;
    frame_release = rel;
    tick();
    sample_valid  = 1'b0;
    frame_release = 1'b0;
  endtask

  task automatic send_mono(input int v);
    send(DB'(v), DB'(v), 1'b0);
  endtask

  task automatic send_range(input int first, input int last);
    for (int v = first; v <= last; v++) send_mono(v);
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int addr, input int exp);
    rd_addr = 3'(addr);
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(frame_ready), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

`ifdef FRAME_BUF_DECIM2_EN
    // Pairs (2,4)->3, (6,8)->7, (-2,-5)->-4 (0xFFFC), then zeros.
    send_mono(2);
    send_mono(4);
    send_mono(6);
    send_mono(8);
    send_mono(-2);
    send_mono(-5);
    for (int i = 0; i < 9; i++) send_mono(0);
    check("dec_ready_15", 32'(frame_ready), 0);
    send_mono(0);
    check("dec_ready_16", 32'(frame_ready), 1);
    rd_chk("dec_rd0", 0, 3);
    rd_chk("dec_rd1", 1, 7);
    rd_chk("dec_rd2", 2, 'hFFFC);
    rd_chk("dec_rd7", 7, 0);
    check("dec_overflow", 32'(overflow), 0);
`else
    // Mono arithmetic corner cases.
    send('h7FFF, 'h7FFF, 1'b0);
    send('h8000, 'h8000, 1'b0);
    send('h0003, 'hFFFF, 1'b0);
    send('h0001, 'h0000, 1'b0);
    send_range(0, 3);
    check("mono_ready", 32'(frame_ready), 1);
    rd_chk("mono_max", 0, 'h7FFF);
    rd_chk("mono_min", 1, 'h8000);
    rd_chk("mono_mixed", 2, 'h0001);
    rd_chk("mono_round", 3, 'h0000);

    // Basic frame: ready exactly after the 8th sample.
    do_reset();
    send_range(0, 6);
    check("basic_ready_7", 32'(frame_ready), 0);
    send_mono(7);
    check("basic_ready_8", 32'(frame_ready), 1);
    for (int a = 0; a < FL; a++) rd_chk("basic_rd", a, a);

    // Ping-pong: fill the second bank, then overflow.
    send_range(8, 15);
    check("pp_ready", 32'(frame_ready), 1);
    check("pp_no_ovf_yet", 32'(overflow), 0);
    send_mono(99);
    check("pp_overflow", 32'(overflow), 1);
    release_frame();
    check("pp_ready_second", 32'(frame_ready), 1);
    for (int a = 0; a < FL; a++) rd_chk("pp_rd_second", a, a + 8);
    tick();
    send_range(20, 27);
    release_frame();
    check("pp_ready_bank0", 32'(frame_ready), 1);
    rd_chk("pp_bank0_first", 0, 20);
    rd_chk("pp_bank0_last", 7, 27);
    check("pp_overflow_sticky", 32'(overflow), 1);

    // Last write into bank 0 coincides with release of bank 1.
    do_reset();
    send_range(0, 7);
    release_frame();
    send_range(10, 17);
    check("sim_bank1_ready", 32'(frame_ready), 1);
    send_range(30, 36);
    send(DB'(37), DB'(37), 1'b1);
    check("sim_overflow", 32'(overflow), 0);
    check("sim_ready_bank0", 32'(frame_ready), 1);
    send_range(50, 57);
    check("sim_no_drop", 32'(overflow), 0);
    rd_chk("sim_bank0_last", 7, 37);
    release_frame();
    check("sim_ready_bank1", 32'(frame_ready), 1);
    rd_chk("sim_bank1_idx0", 0, 50);
    rd_chk("sim_bank1_idx7", 7, 57);

    // Reset mid-frame with one frame ready and overflow set.
    do_reset();
    send_range(0, 15);
    send_mono(99);
    check("rm_overflow_set", 32'(overflow), 1);
    release_frame();
    tick();
    send_range(100, 104);
    check("rm_ready_before", 32'(frame_ready), 1);
    rst = 1'b1;
    tick();
    check("rm_ready_cleared", 32'(frame_ready), 0);
    check("rm_overflow_cleared", 32'(overflow), 0);
    check("rm_rd_data_cleared", 32'(rd_data), 0);
    rst = 1'b0;
    send_range(200, 206);
    check("rm_ready_7", 32'(frame_ready), 0);
    send_mono(207);
    check("rm_ready_8", 32'(frame_ready), 1);
    rd_chk("rm_idx0", 0, 200);
    rd_chk("rm_idx7", 7, 207);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_frame_buffer.md
SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 16, giving the width of one signed two's-complement audio sample.
REQ-002 The block SHALL have parameter FRAME_LEN, default 256, giving the samples per frame; legal values are powers of two, 4 or more.
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_L_i  in  DATA_BITS  left sample, signed.
- sample_R_i  in  DATA_BITS  right sample, signed.
- sample_valid_i  in  1  one-cycle pulse; L/R are valid in that cycle.
- frame_ready_o  out  1  a complete frame is readable.
- rd_addr_i  in  log2(FRAME_LEN)  read index into the ready frame.
- rd_data_o  out  DATA_BITS  sample at rd_addr_i, registered.
- frame_release_i  in  1  one-cycle pulse; the consumer has finished with the ready frame.
- overflow_o  out  1  sticky flag; at least one sample was dropped.

Function
REQ-004 Mono conversion SHALL compute the (DATA_BITS+1)-bit sign-extended sum L+R, arithmetic-shift it right by 1 and truncate to DATA_BITS; the result can never overflow.
- Example: L=0x7FFF, R=0x7FFF gives 0x7FFF.
- Example: L=0x8000, R=0x8000 gives 0x8000.
- Example: L=0x0001, R=0x0000 gives 0x0000.
REQ-005 Storage SHALL be two banks (ping-pong) of FRAME_LEN x DATA_BITS words, with one full flag per bank.
REQ-006 The write FSM SHALL have two states, FILL and STALL.
- FILL: each accepted sample is written to wr_bank[wr_idx], then wr_idx increments.
REQ-007 When the write at wr_idx == FRAME_LEN-1 occurs, the block SHALL do the following:
- Set full[wr_bank] and wrap wr_idx to 0.
- If full[~wr_bank] is 0, toggle wr_bank and stay in FILL.
- Otherwise go to STALL.
REQ-008 In STALL, every sample_valid_i SHALL be dropped and SHALL set overflow_o.
- Once full[~wr_bank] is 0, toggle wr_bank and return to FILL with wr_idx=0.
REQ-009 The read side SHALL use rd_bank, which points at the oldest full bank.
- frame_ready_o = full[rd_bank].
REQ-010 frame_release_i while frame_ready_o=1 SHALL clear full[rd_bank] and toggle rd_bank in the same edge.
- frame_release_i while frame_ready_o=0 is ignored.
REQ-011 rd_data_o SHALL equal bank[rd_bank][rd_addr_i] exactly one cycle after rd_addr_i is presented.
- Its value is don't-care while frame_ready_o=0.
REQ-012 frame_ready_o SHALL rise on the cycle after the edge that wrote the last sample of a frame; latency from the final sample_valid_i is 1 cycle.
REQ-013 Simultaneous last write and release of the other bank in one edge: the release takes priority for the full test, so the FSM stays in FILL on the other bank and no sample is lost.
REQ-014 A release and a sample_valid_i arriving in the same edge while in STALL: that sample SHALL be dropped (overflow set); the FSM returns to FILL on the next edge.
REQ-015 The write side SHALL never write into a bank whose full flag is set.
- Frame contents SHALL be stable from frame_ready_o rising until release.

Reset
REQ-016 While rst=1, the block SHALL hold the following values:
- FSM=FILL, wr_bank=0, rd_bank=0, wr_idx=0.
- full=2'b00, frame_ready_o=0, overflow_o=0, rd_data_o=0.
- Decimation phase=0 (when compiled in).
REQ-017 Reset mid-frame SHALL discard all partially or fully buffered frames; memory contents need not be cleared.
REQ-018 overflow_o SHALL clear only on rst.

Configuration
REQ-019 With macro FRAME_BUF_DECIM2_EN defined, mono samples SHALL be decimated by 2.
- A phase bit toggles on every sample_valid_i, including while in STALL.
- Phase 0: the mono value is held in a register.
- Phase 1: (held + current) is computed at DATA_BITS+1 bits, shifted right arithmetically by 1, and that value is the accepted sample.
- A drop in STALL only sets overflow_o on phase 1.
REQ-020 Without FRAME_BUF_DECIM2_EN, every mono sample is accepted directly, and no phase or hold register is synthesized.

Structure
REQ-021 The following items SHALL live in the shared package:
- The DATA_BITS default.
- The FRAME_LEN default.
- The write-FSM state encoding (FILL, STALL).
- The mono-average helper function.
REQ-022 Each bank SHALL be one instance of sub-module frame_bank_ram: simple dual-port, one write port, one registered read port, inferable as block RAM.

Verification
REQ-023 Mono/arithmetic: feed L/R pairs (0x7FFF,0x7FFF), (0x8000,0x8000), (0x0003,0xFFFF), (0x0001,0x0000) -> stored 0x7FFF, 0x8000, 0x0001, 0x0000.
REQ-024 Basic frame: FRAME_LEN=8, feed 8 ramp samples (mono 0..7) -> frame_ready_o rises 1 cycle after the 8th pulse; reads of addr 0..7 return 0..7 with 1-cycle latency.
REQ-025 Ping-pong: feed 16 samples without release -> both banks full, FSM=STALL, 17th sample dropped, overflow_o=1; release -> frame_ready_o stays 1 showing the second frame (8..15); the next samples fill bank 0.
REQ-026 Simultaneous events: hold bank 1 full, then issue release in the same cycle as the last write into bank 0 -> no STALL entered, overflow_o stays 0, the next sample lands at bank 1 index 0.
REQ-027 Reset mid-operation: assert rst after 5 of 8 samples with one frame ready -> frame_ready_o=0 and overflow_o=0; the next 8 samples form a complete frame starting at index 0.
REQ-028 With FRAME_BUF_DECIM2_EN: feed mono 2,4,6,8 -> stored 3,7; frame_ready_o rises after 2*FRAME_LEN input pulses.
